// File: rtl/mc_cu_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
// MC_CU_MULDIV_EN enables the mult/divu path in every file of this slice.
package mc_cu_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_R     = 4'd7,
        WB_I     = 4'd8,
        WB_MEM   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        MD_WAIT  = 4'd12
    } cu_state_e;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_SLT  = 3'd4;
    localparam logic [2:0] ALU_SLTU = 3'd5;
    localparam logic [2:0] ALU_LUI  = 3'd6;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;
    localparam logic [5:0] F_MULT = 6'h18;
    localparam logic [5:0] F_DIVU = 6'h1B;

    function automatic logic is_md(input logic [5:0] f);
        return (f == F_MULT) || (f == F_DIVU);
    endfunction

endpackage

// File: rtl/mc_cu_alu_dec.sv
// op/func to ALU operation and legality; shared by R and I execute states.
// MC_CU_MULDIV_EN makes mult/divu legal R-type funcs.
module mc_cu_alu_dec
    import mc_cu_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output logic [2:0] ctr,
    output logic       legal
);

    always_comb begin
        ctr   = ALU_ADD;
        legal = 1'b1;
        if (op == OP_RTYPE) begin
            unique case (func)
                F_ADDU: ctr = ALU_ADD;
                F_SUBU: ctr = ALU_SUB;
                F_AND:  ctr = ALU_AND;
                F_OR:   ctr = ALU_OR;
                F_SLT:  ctr = ALU_SLT;
                F_SLTU: ctr = ALU_SLTU;
`ifdef MC_CU_MULDIV_EN
                F_MULT, F_DIVU: ctr = ALU_ADD;
`endif
                default: legal = 1'b0;
            endcase
        end else begin
            unique case (op)
                OP_ADDIU, OP_LW, OP_SW, OP_J: ctr = ALU_ADD;
                OP_BEQ, OP_BNE:               ctr = ALU_SUB;
                OP_ANDI:                      ctr = ALU_AND;
                OP_ORI:                       ctr = ALU_OR;
                OP_SLTI:                      ctr = ALU_SLT;
                OP_LUI:                       ctr = ALU_LUI;
                default:                      legal = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM driving datapath enables per state.
// MC_CU_MULDIV_EN adds the MD_WAIT state and the md_start/md_done handshake.
module mc_control_unit
    import mc_cu_pkg::*;
#(
    parameter int ALUCTR_W = 4,
    parameter int STATE_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          op,
    input  logic [5:0]          func,
    input  logic                zero,
    input  logic                mem_ready,
    input  logic                md_done,
    output logic                PCWr,
    output logic                IRWr,
    output logic                MemRd,
    output logic                MemWr,
    output logic                RegWr,
    output logic                RegDst,
    output logic                MemtoReg,
    output logic                ALUSrcA,
    output logic                Extop,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSrc,
    output logic [ALUCTR_W-1:0] ALUctr,
    output logic                md_start,
    output logic                illegal,
    output logic [STATE_W-1:0]  state
);

    cu_state_e  state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       md_start_q, md_start_d;
    // Holds all enables low until the first edge after reset release.
    logic       run_q;
    logic [2:0] dec_ctr;
    logic       dec_legal;
    logic [2:0] aluc;

    mc_cu_alu_dec u_alu_dec (
        .op    (op),
        .func  (func),
        .ctr   (dec_ctr),
        .legal (dec_legal)
    );

`ifndef MC_CU_MULDIV_EN
    logic unused_md_done;
    assign unused_md_done = md_done;
`endif

    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        md_start_d = 1'b0;
        PCWr = 1'b0; IRWr = 1'b0; MemRd = 1'b0; MemWr = 1'b0;
        RegWr = 1'b0; RegDst = 1'b0; MemtoReg = 1'b0;
        ALUSrcA = 1'b0; Extop = 1'b0;
        ALUSrcB = 2'b00; PCSrc = 2'b00;
        aluc = ALU_ADD;
        if (run_q) begin
            unique case (state_q)
                FETCH: begin
                    MemRd   = 1'b1;
                    ALUSrcB = 2'b01;
                    if (mem_ready) begin
                        PCWr    = 1'b1;
                        IRWr    = 1'b1;
                        state_d = DECODE;
                    end
                end
                DECODE: begin
                    ALUSrcB = 2'b11;
                    Extop   = 1'b1;
                    if (!dec_legal) begin
                        illegal_d = 1'b1;
                        state_d   = FETCH;
                    end else if (op == OP_RTYPE) begin
                        state_d = EXEC_R;
                    end else begin
                        unique case (op)
                            OP_LW, OP_SW:   state_d = MEM_ADDR;
                            OP_BEQ, OP_BNE: state_d = BRANCH;
                            OP_J:           state_d = JUMP;
                            default:        state_d = EXEC_I;
                        endcase
                    end
                end
                EXEC_R: begin
                    ALUSrcA = 1'b1;
                    aluc    = dec_ctr;
                    state_d = WB_R;
`ifdef MC_CU_MULDIV_EN
                    if (is_md(func)) state_d = MD_WAIT;
`endif
                end
                EXEC_I: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    aluc    = dec_ctr;
                    Extop   = !((op == OP_ANDI) || (op == OP_ORI));
                    state_d = WB_I;
                end
                MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    Extop   = 1'b1;
                    state_d = (op == OP_LW) ? MEM_RD : MEM_WR;
                end
                MEM_RD: begin
                    MemRd = 1'b1;
                    if (mem_ready) state_d = WB_MEM;
                end
                MEM_WR: begin
                    MemWr = 1'b1;
                    if (mem_ready) state_d = FETCH;
                end
                WB_R: begin
                    RegWr   = 1'b1;
                    RegDst  = 1'b1;
                    state_d = FETCH;
                end
                WB_I: begin
                    RegWr   = 1'b1;
                    state_d = FETCH;
                end
                WB_MEM: begin
                    RegWr    = 1'b1;
                    MemtoReg = 1'b1;
                    state_d  = FETCH;
                end
                BRANCH: begin
                    ALUSrcA = 1'b1;
                    aluc    = ALU_SUB;
                    PCSrc   = 2'b01;
                    PCWr    = (op == OP_BEQ) ? zero : !zero;
                    state_d = FETCH;
                end
                JUMP: begin
                    PCSrc   = 2'b10;
                    PCWr    = 1'b1;
                    state_d = FETCH;
                end
`ifdef MC_CU_MULDIV_EN
                MD_WAIT: begin
                    if (md_done) state_d = FETCH;
                end
`endif
                default: state_d = FETCH;
            endcase
        end
`ifdef MC_CU_MULDIV_EN
        md_start_d = (state_d == MD_WAIT) && (state_q != MD_WAIT);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            illegal_q  <= 1'b0;
            md_start_q <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            illegal_q  <= illegal_d;
            md_start_q <= md_start_d;
            run_q      <= 1'b1;
        end
    end

    assign ALUctr   = ALUCTR_W'(aluc);
    assign md_start = md_start_q;
    assign illegal  = illegal_q;
    assign state    = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized bench: per-instruction expected output traces vs the DUT.
// Honours MC_CU_MULDIV_EN the same way as the design.
module tb_mc_control_unit;
    import mc_cu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op, func;
    logic       zero, mem_ready, md_done;
    logic       PCWr, IRWr, MemRd, MemWr, RegWr, RegDst, MemtoReg;
    logic       ALUSrcA, Extop, md_start, illegal;
    logic [1:0] ALUSrcB, PCSrc;
    logic [3:0] ALUctr, state;

    mc_control_unit #(.ALUCTR_W(4), .STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .func(func), .zero(zero),
        .mem_ready(mem_ready), .md_done(md_done),
        .PCWr(PCWr), .IRWr(IRWr), .MemRd(MemRd), .MemWr(MemWr),
        .RegWr(RegWr), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .ALUSrcA(ALUSrcA), .Extop(Extop), .ALUSrcB(ALUSrcB),
        .PCSrc(PCSrc), .ALUctr(ALUctr), .md_start(md_start),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcwr, irwr, memrd, memwr, regwr, regdst, memtoreg;
        logic       srca, extop;
        logic [1:0] srcb, pcsrc;
        logic [3:0] ctr;
        logic       mds;
        logic [3:0] st;
        logic       ill;
    } vec_t;

    typedef struct {
        logic rdy;
        logic mdd;
        vec_t v;
    } ent_t;

    localparam int CL_R = 0, CL_MD = 1, CL_I = 2, CL_LW = 3;
    localparam int CL_SW = 4, CL_BR = 5, CL_J = 6;

    ent_t tq[$];
    logic ill_m;
    int   n_vec = 0;
    int   n_bad = 0;

    logic [5:0] ops [0:13] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04,
                               6'h05, 6'h02, 6'h09, 6'h0C, 6'h0D, 6'h0A,
                               6'h0F, 6'h3F};
    logic [5:0] fns [0:8]  = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2B,
                               6'h18, 6'h1B, 6'h00};

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic vec_t base(cu_state_e st, logic [3:0] c);
        vec_t v = '0;
        v.st  = st;
        v.ctr = c;
        v.ill = ill_m;
        return v;
    endfunction

    function automatic vec_t sample();
        vec_t v;
        v.pcwr = PCWr; v.irwr = IRWr; v.memrd = MemRd; v.memwr = MemWr;
        v.regwr = RegWr; v.regdst = RegDst; v.memtoreg = MemtoReg;
        v.srca = ALUSrcA; v.extop = Extop; v.srcb = ALUSrcB;
        v.pcsrc = PCSrc; v.ctr = ALUctr; v.mds = md_start;
        v.st = state; v.ill = illegal;
        return v;
    endfunction

    task automatic push(vec_t v, logic rdy, logic mdd);
        ent_t e;
        e.rdy = rdy;
        e.mdd = mdd;
        e.v   = v;
        tq.push_back(e);
    endtask

    // Instruction classification and ALU code straight from the ISA table.
    task automatic spec_dec(input logic [5:0] o, input logic [5:0] f,
                            output logic lg, output logic [3:0] c,
                            output int cls);
        lg = 1'b1; c = 4'd0; cls = CL_I;
        if (o == 6'h00) begin
            cls = CL_R;
            case (f)
                6'h21: c = 4'd0;
                6'h23: c = 4'd1;
                6'h24: c = 4'd2;
                6'h25: c = 4'd3;
                6'h2A: c = 4'd4;
                6'h2B: c = 4'd5;
`ifdef MC_CU_MULDIV_EN
                6'h18, 6'h1B: cls = CL_MD;
`endif
                default: lg = 1'b0;
            endcase
        end else begin
            case (o)
                6'h09: c = 4'd0;
                6'h0C: c = 4'd2;
                6'h0D: c = 4'd3;
                6'h0A: c = 4'd4;
                6'h0F: c = 4'd6;
                6'h23: cls = CL_LW;
                6'h2B: cls = CL_SW;
                6'h04, 6'h05: cls = CL_BR;
                6'h02: cls = CL_J;
                default: lg = 1'b0;
            endcase
        end
    endtask

    task automatic mem_wait(vec_t v, int waits);
        repeat (waits) push(v, 1'b0, rb());
        push(v, 1'b1, rb());
    endtask

    task automatic build(logic [5:0] o, logic [5:0] f, logic z,
                         int nf, int nm, int nmd);
        vec_t v;
        logic lg;
        logic [3:0] c;
        int cls;
        v = base(FETCH, 4'd0); v.memrd = 1'b1; v.srcb = 2'b01;
        repeat (nf) push(v, 1'b0, rb());
        v.pcwr = 1'b1; v.irwr = 1'b1;
        push(v, 1'b1, rb());
        v = base(DECODE, 4'd0); v.srcb = 2'b11; v.extop = 1'b1;
        push(v, rb(), rb());
        spec_dec(o, f, lg, c, cls);
        if (!lg) begin
            ill_m = 1'b1;
            return;
        end
        case (cls)
            CL_R: begin
                v = base(EXEC_R, c); v.srca = 1'b1; push(v, rb(), rb());
                v = base(WB_R, 4'd0); v.regwr = 1'b1; v.regdst = 1'b1;
                push(v, rb(), rb());
            end
            CL_MD: begin
                v = base(EXEC_R, 4'd0); v.srca = 1'b1; push(v, rb(), rb());
                v = base(MD_WAIT, 4'd0); v.mds = 1'b1;
                for (int i = 0; i <= nmd; i++) begin
                    push(v, rb(), i == nmd);
                    v.mds = 1'b0;
                end
            end
            CL_I: begin
                v = base(EXEC_I, c); v.srca = 1'b1; v.srcb = 2'b10;
                v.extop = !(o == 6'h0C || o == 6'h0D);
                push(v, rb(), rb());
                v = base(WB_I, 4'd0); v.regwr = 1'b1; push(v, rb(), rb());
            end
            CL_LW, CL_SW: begin
                v = base(MEM_ADDR, 4'd0); v.srca = 1'b1; v.srcb = 2'b10;
                v.extop = 1'b1;
                push(v, rb(), rb());
                if (cls == CL_LW) begin
                    v = base(MEM_RD, 4'd0); v.memrd = 1'b1; mem_wait(v, nm);
                    v = base(WB_MEM, 4'd0); v.regwr = 1'b1; v.memtoreg = 1'b1;
                    push(v, rb(), rb());
                end else begin
                    v = base(MEM_WR, 4'd0); v.memwr = 1'b1; mem_wait(v, nm);
                end
            end
            CL_BR: begin
                v = base(BRANCH, 4'd1); v.srca = 1'b1; v.pcsrc = 2'b01;
                v.pcwr = (o == 6'h04) ? z : !z;
                push(v, rb(), rb());
            end
            default: begin
                v = base(JUMP, 4'd0); v.pcsrc = 2'b10; v.pcwr = 1'b1;
                push(v, rb(), rb());
            end
        endcase
    endtask

    // Plays the first n trace cycles (all when n < 0), one per clock.
    task automatic play(logic [5:0] o, logic [5:0] f, logic z, int n);
        int k = (n < 0) ? tq.size() : n;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            op = o; func = f; zero = z;
            mem_ready = tq[i].rdy;
            md_done   = tq[i].mdd;
            #1;
            chk($sformatf("op%h/f%h z%0b cyc%0d", o, f, z, i),
                32'(sample()), 32'(tq[i].v));
        end
        tq.delete();
    endtask

    task automatic run(logic [5:0] o, logic [5:0] f, logic z,
                       int nf, int nm, int nmd);
        build(o, f, z, nf, nm, nmd);
        play(o, f, z, -1);
    endtask

    vec_t rst_v;

    initial begin
        rst_n = 1'b0; op = '0; func = '0; zero = 1'b0;
        mem_ready = 1'b0; md_done = 1'b0; ill_m = 1'b0;
        rst_v = '0; rst_v.st = FETCH;
        repeat (2) @(negedge clk);
        #1 chk("reset", 32'(sample()), 32'(rst_v));
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("release", 32'(sample()), 32'(rst_v));

        run(6'h00, 6'h21, 1'b0, 0, 0, 0);
        run(6'h23, 6'h00, 1'b0, 2, 3, 0);
        run(6'h04, 6'h00, 1'b1, 0, 0, 0);
        run(6'h04, 6'h00, 1'b0, 0, 0, 0);
        run(6'h05, 6'h00, 1'b1, 0, 0, 0);
        run(6'h05, 6'h00, 1'b0, 0, 0, 0);
        run(6'h3F, 6'h00, 1'b0, 0, 0, 0);
        run(6'h00, 6'h18, 1'b0, 0, 0, 5);
        run(6'h00, 6'h1B, 1'b0, 1, 0, 0);

        for (int i = 0; i < 60; i++) begin
            logic [5:0] o, f;
            o = ops[$urandom_range(0, 13)];
            f = (o == 6'h00) ? fns[$urandom_range(0, 8)]
                             : 6'($urandom_range(0, 63));
            run(o, f, rb(), $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 3));
        end

        // Reset during a stalled store, then resume from FETCH.
        build(6'h2B, 6'h00, 1'b0, 0, 3, 0);
        play(6'h2B, 6'h00, 1'b0, 4);
        @(negedge clk);
        rst_n = 1'b0;
        ill_m = 1'b0;
        #1 chk("rst_mid_memwr", 32'(sample()), 32'(rst_v));
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_mid_release", 32'(sample()), 32'(rst_v));
        run(6'h00, 6'h25, 1'b0, 1, 0, 0);
        run(6'h0D, 6'h00, 1'b0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
